// File: rtl/serial_adder.sv
// Bit-serial adder: captures A/B/CIN on START, adds one bit per clock LSB first,
// then publishes Q/Cout and pulses DONE for one cycle.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, q_q, q_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sum_bit, carry_bit, capture;
  logic [WIDTH-1:0] res_shift;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_bit = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // Sum bits enter from the MSB side so the LSB lands in bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = sum_bit;
    end else begin : g_res_wn
      assign res_shift = {sum_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cout_d  = cout_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) capture = 1'b1;
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_bit;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          q_d     = res_shift;
          cout_d  = carry_bit;
          state_d = FIN;
        end
      end
      FIN: begin
        if (START) capture = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      a_d     = A;
      b_d     = B;
      c_d     = CIN;
      res_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);
  assign Q    = q_q;
  assign Cout = cout_q;

endmodule
